// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  // Result of a frame evaluation. At most one field is set in any cycle.
  typedef struct packed {
    logic good;
    logic parity_err;
    logic frame_err;
  } ps2_eval_t;

  // PS/2 uses odd parity across the data byte and the parity bit.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pin: synchronizer, stability filter and a
// one-cycle strobe on each filtered 1->0 transition.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic fall
);

  localparam int            CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q;
  logic [CW-1:0]          cnt_q;
  logic                   fall_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign fall   = fall_q;

  // Sync the pin, then accept a new level only after it has been seen on
  // FILTER_CYCLES consecutive samples; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      fall_q <= 1'b0;
      if (synced != filt_q) begin
        if (cnt_q == CNT_LAST) begin
          filt_q <= synced;
          cnt_q  <= '0;
          fall_q <= filt_q;  // only a high->low change is a sample strobe
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_deserializer.sv
// PS/2 device-to-host receiver: line conditioning, 11-bit frame
// deserialization, odd-parity/stop checks and a one-byte holding register
// with valid/ack handshake and sticky overrun.
// Optional macro PS2_RX_TIMEOUT_EN adds an inter-edge timeout that aborts
// stalled frames with a frame error.
module ps2_rx_deserializer
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     ps2_clk_in,
  input  logic                     ps2_dat_in,
  output logic [PS2_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ack,
  output logic                     rx_parity_err,
  output logic                     rx_frame_err,
  output logic                     rx_overrun,
  output logic                     rx_busy
);

  localparam int           BW       = $clog2(PS2_DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(PS2_DATA_BITS - 1);

  logic                     strobe;
  logic [SYNC_STAGES-1:0]   dat_sync_q;
  logic                     dat_s;
  ps2_state_t               state_q, state_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     par_q, par_d;
  logic                     timeout;
  ps2_eval_t                eval;

  ps2_line_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filter (
    .clk (CLOCK_50),
    .rst (reset),
    .pin (ps2_clk_in),
    .fall(strobe)
  );

  // Data line only needs synchronizing; it is sampled on clock strobes.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) dat_sync_q <= '1;
    else       dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_in};
  end

  assign dat_s   = dat_sync_q[SYNC_STAGES-1];
  assign rx_busy = (state_q != IDLE);

`ifdef PS2_RX_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q;

  // A real strobe on the expiry cycle wins over the timeout.
  assign timeout = (state_q != IDLE) && !strobe && (to_cnt_q == TO_LAST);

  // Cycles since the last accepted clock edge while inside a frame.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                                         to_cnt_q <= '0;
    else if ((state_q == IDLE) || strobe || timeout)   to_cnt_q <= '0;
    else                                               to_cnt_q <= to_cnt_q + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // Frame FSM state and shift register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
    end
  end

  // Next state: advances only on a clock strobe; the stop bit is judged
  // with frame error taking precedence over parity error.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    eval      = '0;
    if (strobe) begin
      case (state_q)
        IDLE: begin
          // a high data line here is a stray edge, not a start bit
          if (!dat_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shreg_d[bit_cnt_q] = dat_s;
          if (bit_cnt_q == LAST_BIT) state_d   = PARITY;
          else                       bit_cnt_d = bit_cnt_q + BW'(1);
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s)                             eval.frame_err  = 1'b1;
          else if (!odd_parity_ok(shreg_q, par_q)) eval.parity_err = 1'b1;
          else                                    eval.good       = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d        = IDLE;
      eval.frame_err = 1'b1;
    end
  end

  // Holding register, handshake and error pulses. An ack arriving with a
  // good frame frees the slot in the same cycle, so no overrun is flagged.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_parity_err <= eval.parity_err;
      rx_frame_err  <= eval.frame_err;
      if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (eval.good) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shreg_q;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// Directed + randomized bench for ps2_rx_deserializer with a frame-level
// reference model of the holding register and error reporting.
module tb_ps2_rx_deserializer;
  import ps2_pkg::*;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int TO   = 200;
  localparam int HALF = 20;               // PS/2 half period in system clocks
  localparam int LAT  = SYNC + FILT + 1;  // stop fall -> rx_valid

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_dat_in = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy;

  ps2_rx_deserializer #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .ps2_clk_in   (ps2_clk_in),
    .ps2_dat_in   (ps2_dat_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int par_pulses = 0;
  int frm_pulses = 0;

  // reference model of the consumer-visible state
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_over  = 1'b0;
  bit         tr [0:HALF];

  // count cycles each error pulse is high
  always @(posedge CLOCK_50) begin
    if (rx_parity_err) par_pulses <= par_pulses + 1;
    if (rx_frame_err)  frm_pulses <= frm_pulses + 1;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive nbits of a frame; glitch adds short low pulses in high phases;
  // ack_stop raises rx_ack on the stop-evaluation cycle.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                            input int nbits, input bit glitch, input bit ack_stop);
    logic [PS2_FRAME_BITS-1:0] f;
    int g;
    f = {stp, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat_in = f[i];
      g = 1 + (i % 3);
      for (int k = 0; k < HALF; k++) begin
        tick();
        ps2_clk_in = !(glitch && k >= 5 && k < 5 + g);
      end
      tick();
      ps2_clk_in = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        tick();
        rx_ack = ack_stop && (i == PS2_FRAME_BITS - 1) && (k == LAT - 1);
        @(negedge CLOCK_50);
        tr[k] = rx_valid;
      end
    end
    tick();
    ps2_clk_in = 1'b1;
    ps2_dat_in = 1'b1;
    repeat (HALF) tick();
  endtask

  task automatic ack_pulse();
    tick();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_over  = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge CLOCK_50);
    chk({tag, ".valid"},   rx_valid,   m_valid);
    chk({tag, ".data"},    rx_data,    m_data);
    chk({tag, ".overrun"}, rx_overrun, m_over);
    chk({tag, ".busy"},    rx_busy,    1'b0);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] d, input logic p,
                             input logic stp, input bit glitch, input bit ack_stop);
    int p0, f0, ep, ef;
    bit pre_valid, good;
    p0 = par_pulses;
    f0 = frm_pulses;
    pre_valid = m_valid;
    send_frame(d, p, stp, PS2_FRAME_BITS, glitch, ack_stop);
    good = 0; ep = 0; ef = 0;
    if (!stp)                                   ef = 1;
    else if ((($countones(d) + int'(p)) % 2) == 0) ep = 1;
    else                                        good = 1;
    if (ack_stop && m_valid && !good) begin
      m_valid = 1'b0;
      m_over  = 1'b0;
    end
    if (good) begin
      if (!m_valid || ack_stop) begin
        m_data  = d;
        m_valid = 1'b1;
        m_over  = 1'b0;
      end else begin
        m_over = 1'b1;
      end
    end
    check_state(tag);
    chk({tag, ".par_pulse"}, par_pulses - p0, ep);
    chk({tag, ".frm_pulse"}, frm_pulses - f0, ef);
    if (good && !pre_valid) begin
      chk({tag, ".lat_before"}, tr[LAT-1], 1'b0);
      chk({tag, ".lat_at"},     tr[LAT],   1'b1);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic p, s;
    bit a;
    int f0;

    // reset state
    repeat (5) tick();
    @(negedge CLOCK_50);
    chk("rst.data", rx_data, 8'h00);
    chk("rst.valid", rx_valid, 1'b0);
    chk("rst.perr", rx_parity_err, 1'b0);
    chk("rst.ferr", rx_frame_err, 1'b0);
    chk("rst.ovr", rx_overrun, 1'b0);
    chk("rst.busy", rx_busy, 1'b0);
    tick();
    reset = 1'b0;
    repeat (5) tick();

    // basic good frame, then ack
    frame_check("t1", 8'h1C, 1'b0, 1'b1, 0, 0);
    ack_pulse();
    @(negedge CLOCK_50);
    chk("t1.ack_valid", rx_valid, 1'b0);

    // parity error
    frame_check("t2", 8'hF0, 1'b0, 1'b1, 0, 0);

    // framing error, then recovery
    frame_check("t3a", 8'h1C, 1'b0, 1'b0, 0, 0);
    frame_check("t3b", 8'hF0, 1'b1, 1'b1, 0, 0);
    ack_pulse();

    // overrun, then ack coinciding with a good frame
    frame_check("t4a", 8'h1C, 1'b0, 1'b1, 0, 0);
    frame_check("t4b", 8'hF0, 1'b1, 1'b1, 0, 0);
    frame_check("t4c", 8'h55, 1'b1, 1'b1, 0, 1);
    ack_pulse();
    check_state("t4ack");

    // glitches on the clock line
    frame_check("t5", 8'h1C, 1'b0, 1'b1, 1, 0);
    ack_pulse();

    // randomized frames
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      p = ~(^d);
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 9) != 0);
      a = ($urandom_range(0, 5) == 0);
      frame_check($sformatf("rnd%0d", i), d, p, s, $urandom_range(0, 3) == 0, a);
      if ($urandom_range(0, 1) == 1) ack_pulse();
    end
    ack_pulse();

`ifdef PS2_RX_TIMEOUT_EN
    // stalled frame aborted by the inter-edge timeout
    f0 = frm_pulses;
    send_frame(8'hA5, 1'b0, 1'b1, 5, 0, 0);
    @(negedge CLOCK_50);
    chk("t6.busy_mid", rx_busy, 1'b1);
    repeat (TO + 50) tick();
    check_state("t6.after");
    chk("t6.frm_pulse", frm_pulses - f0, 1);
    frame_check("t6.next", 8'h1C, 1'b0, 1'b1, 0, 0);
`endif

    // reset in the middle of a frame while a byte is held
    frame_check("t7.pre", 8'h3C, 1'b1, 1'b1, 0, 0);
    send_frame(8'h00, 1'b0, 1'b1, 4, 0, 0);
    @(negedge CLOCK_50);
    chk("t7.busy_mid", rx_busy, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge CLOCK_50);
    chk("t7.rst_data", rx_data, 8'h00);
    chk("t7.rst_valid", rx_valid, 1'b0);
    chk("t7.rst_ovr", rx_overrun, 1'b0);
    chk("t7.rst_busy", rx_busy, 1'b0);
    chk("t7.rst_perr", rx_parity_err, 1'b0);
    chk("t7.rst_ferr", rx_frame_err, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_over  = 1'b0;
    repeat (5) tick();
    frame_check("t7.post", 8'hF0, 1'b1, 1'b1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
